fp_exc_status_unit: RTL and testbench

- Consumer end of the add/sub exception interface: takes each final result byte and its 5-bit exception flag vector from the FP add/sub datapath.
- Accumulates flags into a sticky accrued-status register and applies a software-programmable trap-enable mask.
- Raises a trap request with a req/ack handshake, stalling the datapath while pending.
- Provides a register read/write port for status, mask and trap-count access.

---
 rtl/fp_exc_pkg.sv | 14 +
 rtl/fp_exc_trap_fsm.sv | 47 ++++
 rtl/fp_exc_status_unit.sv | 59 +++++
 tb/tb_fp_exc_status_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fp_exc_pkg.sv
// fp_exc_pkg: shared flag indices, flag vector type, trap state and register selects for the FP exception status unit
//   no ports; imported by fp_exc_trap_fsm and fp_exc_status_unit
package fp_exc_pkg;
   localparam int FLG_OF = 4;
   localparam int FLG_UF = 3;
   localparam int FLG_DZ = 2;
   localparam int FLG_NV = 1;
   localparam int FLG_NX = 0;
   typedef logic [4:0] exc_flags_t;
   typedef enum logic {RUN, TRAP} state_t;
   localparam logic [1:0] SEL_ACCRUED = 2'd0;
   localparam logic [1:0] SEL_MASK    = 2'd1;
   localparam logic [1:0] SEL_COUNT   = 2'd2;
endpackage

// File: rtl/fp_exc_trap_fsm.sv
// fp_exc_trap_fsm: RUN/TRAP handshake, trap cause/result capture and saturating trap counter
//   in : clk, rst (async, high), accept, flags, res_p, mask, trap_ack
//   out: res_ready, trap_req, trap_cause, trap_result, count
module fp_exc_trap_fsm
   import fp_exc_pkg::*;
#(
   parameter int DW = 8,
   parameter int NF = 5,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          accept,
   input  logic [NF-1:0] flags,
   input  logic [DW-1:0] res_p,
   input  logic [NF-1:0] mask,
   input  logic          trap_ack,
   output logic          res_ready,
   output logic          trap_req,
   output logic [NF-1:0] trap_cause,
   output logic [DW-1:0] trap_result,
   output logic [CW-1:0] count
);
   state_t state, state_nxt;
   logic   hit;
   assign hit = accept & |(flags & mask);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         trap_cause  <= '0;
         trap_result <= '0;
         count       <= '0;
      end else begin
         state <= state_nxt;
         if (hit) begin
            trap_cause  <= flags & mask;
            trap_result <= res_p;
            count       <= count + CW'(~&count);
         end
      end
   end
   always_comb begin
      state_nxt = (state == RUN) ? (hit ? TRAP : RUN) : (trap_ack ? RUN : TRAP);
      res_ready = (state == RUN);
      trap_req  = (state == TRAP);
   end
endmodule

// File: rtl/fp_exc_status_unit.sv
// fp_exc_status_unit: sticky accrued FP exception flags, trap mask, trap request handshake and register port
//   in : clk, rst (async, high), res_valid, res_p, res_flags, trap_ack, reg_wr, reg_sel, reg_wdata
//   out: res_ready, trap_req, trap_cause, trap_result, reg_rdata
module fp_exc_status_unit
   import fp_exc_pkg::*;
#(
   parameter int DW = 8,
   parameter int NF = 5,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          res_valid,
   output logic          res_ready,
   input  logic [DW-1:0] res_p,
   input  logic [NF-1:0] res_flags,
   output logic          trap_req,
   input  logic          trap_ack,
   output logic [NF-1:0] trap_cause,
   output logic [DW-1:0] trap_result,
   input  logic          reg_wr,
   input  logic [1:0]    reg_sel,
   input  logic [NF-1:0] reg_wdata,
   output logic [CW-1:0] reg_rdata
);
   logic [NF-1:0] accrued, mask;
   logic [CW-1:0] count;
   logic          accept;
   assign accept = res_valid & res_ready;
   // A software write to accrued still merges flags accepted in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accrued <= '0;
         mask    <= '0;
      end else begin
         accrued <= ((reg_wr && reg_sel == SEL_ACCRUED) ? reg_wdata : accrued) | (accept ? res_flags : '0);
         if (reg_wr && reg_sel == SEL_MASK) mask <= reg_wdata;
      end
   end
   always_comb begin
      reg_rdata = (reg_sel == SEL_ACCRUED) ? CW'(accrued) :
                  (reg_sel == SEL_MASK)    ? CW'(mask)    :
                  (reg_sel == SEL_COUNT)   ? count        : '0;
   end
   fp_exc_trap_fsm #(.DW(DW), .NF(NF), .CW(CW)) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .accept      (accept),
      .flags       (res_flags),
      .res_p       (res_p),
      .mask        (mask),
      .trap_ack    (trap_ack),
      .res_ready   (res_ready),
      .trap_req    (trap_req),
      .trap_cause  (trap_cause),
      .trap_result (trap_result),
      .count       (count)
   );
endmodule

// File: tb/tb_fp_exc_status_unit.sv
// tb_fp_exc_status_unit: directed vectors against a behavioural model of the exception status unit
module tb_fp_exc_status_unit;
   logic       clk = 0, rst = 1;
   logic       res_valid = 0, trap_ack = 0, reg_wr = 0;
   logic [7:0] res_p = 0;
   logic [4:0] res_flags = 0, reg_wdata = 0;
   logic [1:0] reg_sel = 0;
   logic       res_ready, trap_req;
   logic [4:0] trap_cause;
   logic [7:0] trap_result, reg_rdata;
   int n_chk = 0, n_fail = 0;

   fp_exc_status_unit dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
      .res_flags(res_flags), .trap_req(trap_req), .trap_ack(trap_ack), .trap_cause(trap_cause),
      .trap_result(trap_result), .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata)
   );

   always #5 clk = ~clk;

   // model state kept as plain integers
   int m_acc, m_mask, m_cnt, m_cause, m_res;
   bit m_trap;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_acc = 0; m_mask = 0; m_cnt = 0; m_cause = 0; m_res = 0; m_trap = 0;
      end else begin
         automatic bit took = res_valid && !m_trap;
         automatic int old_mask = m_mask;
         if (reg_wr && reg_sel == 0) m_acc = reg_wdata;
         if (reg_wr && reg_sel == 1) m_mask = reg_wdata;
         if (took) m_acc = m_acc | res_flags;
         if (m_trap) begin
            if (trap_ack) m_trap = 0;
         end else if (took && (res_flags & old_mask) != 0) begin
            m_trap = 1;
            m_cause = res_flags & old_mask;
            m_res = res_p;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         end
      end
   end

   function automatic int exp_rdata(input logic [1:0] s);
      return (s == 0) ? m_acc : (s == 1) ? m_mask : (s == 2) ? m_cnt : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_ready", res_ready, !m_trap);
      chk("m_req", trap_req, m_trap);
      chk("m_cause", trap_cause, m_cause);
      chk("m_result", trap_result, m_res);
      chk("m_rdata", reg_rdata, exp_rdata(reg_sel));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] s, input string name, input logic [31:0] exp);
      reg_sel = s;
      #1;
      chk(name, reg_rdata, exp);
   endtask

   initial begin
      repeat (2) cyc();
      chk("rst_ready", res_ready, 1);
      chk("rst_req", trap_req, 0);
      rd(0, "rst_acc", 0);
      rst = 0;
      cyc();
      // 1: flag with mask 0 accumulates, no trap
      res_valid = 1; res_p = 8'h11; res_flags = 5'b00001;
      cyc();
      res_valid = 0;
      rd(0, "t1_acc", 8'h01);
      chk("t1_req", trap_req, 0);
      chk("t1_ready", res_ready, 1);
      // 2: trap on OF with result capture and held-off ack
      reg_wr = 1; reg_sel = 1; reg_wdata = 5'b10000;
      cyc();
      reg_wr = 0;
      res_valid = 1; res_p = 8'h70; res_flags = 5'b10001;
      cyc();
      res_flags = 5'b00100;
      chk("t2_req", trap_req, 1);
      chk("t2_cause", trap_cause, 5'b10000);
      chk("t2_result", trap_result, 8'h70);
      chk("t2_ready", res_ready, 0);
      rd(2, "t2_cnt", 1);
      repeat (5) cyc();
      res_valid = 0;
      chk("t2_hold_req", trap_req, 1);
      chk("t2_hold_result", trap_result, 8'h70);
      rd(0, "t2_noacc", 8'h11);
      trap_ack = 1;
      cyc();
      trap_ack = 0;
      chk("t2_ack_ready", res_ready, 1);
      chk("t2_ack_req", trap_req, 0);
      // 3: software clear coincident with accept keeps new flags
      reg_wr = 1; reg_sel = 0; reg_wdata = 5'b00011;
      cyc();
      rd(0, "t3_pre", 8'h03);
      reg_wdata = 5'b00000; res_valid = 1; res_flags = 5'b01000;
      cyc();
      reg_wr = 0; res_valid = 0;
      rd(0, "t3_acc", 8'h08);
      // zero flags: no change, no trap
      res_valid = 1; res_flags = 5'b00000;
      cyc();
      res_valid = 0;
      rd(0, "t3_zero", 8'h08);
      chk("t3_zero_req", trap_req, 0);
      // 4: mask write coincident with accept uses old mask
      reg_wr = 1; reg_sel = 1; reg_wdata = 5'b00000;
      cyc();
      reg_wdata = 5'b00010; res_valid = 1; res_p = 8'h2A; res_flags = 5'b00010;
      cyc();
      reg_wr = 0;
      chk("t4_first_req", trap_req, 0);
      cyc();
      res_valid = 0;
      chk("t4_req", trap_req, 1);
      chk("t4_cause", trap_cause, 5'b00010);
      chk("t4_result", trap_result, 8'h2A);
      // mask cleared while trapped: trap stays pending
      reg_wr = 1; reg_sel = 1; reg_wdata = 5'b00000;
      cyc();
      reg_wr = 0;
      cyc();
      chk("t4_maskclr_req", trap_req, 1);
      trap_ack = 1;
      reg_wr = 1; reg_wdata = 5'b00010;
      cyc();
      trap_ack = 0; reg_wr = 0;
      chk("t4_ack_req", trap_req, 0);
      // 5: counter saturation
      for (int i = 0; i < 256; i++) begin
         res_valid = 1; res_flags = 5'b00010;
         cyc();
         res_valid = 0; trap_ack = 1;
         cyc();
         trap_ack = 0;
      end
      rd(2, "t5_cnt", 8'hFF);
      // 6: async reset mid-trap
      res_valid = 1; res_p = 8'h5C; res_flags = 5'b00010;
      cyc();
      res_valid = 0;
      chk("t6_req_pre", trap_req, 1);
      #1 rst = 1;
      #1;
      chk("t6_req", trap_req, 0);
      chk("t6_ready", res_ready, 1);
      chk("t6_cause", trap_cause, 0);
      chk("t6_result", trap_result, 0);
      rd(0, "t6_acc", 0);
      rd(1, "t6_mask", 0);
      rd(2, "t6_cnt", 0);
      cyc();
      rst = 0;
      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
